// File: rtl/rob_commit.sv
// rob_commit - 64-entry reorder buffer between rename/dispatch and the
// architectural register file.
//
// Allocates up to 4 in-order entries per cycle (lanes A-D), accepts up to 3
// out-of-order completions per cycle and retires up to RETIRE_W consecutive
// completed head entries per cycle onto registered write ports.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 (ROB_FLUSH_EN only) discard all entries
//   alloc_req/has_dest/dest   allocation lanes, bit0 = lane A
//   alloc_ready           free entries >= 4
//   rob_loc*/rob_waddr*/rob_wen*  rename-tag write ports, lanes A-D
//   cmp_en*/cmp_tag*/cmp_data*    completion ports 0-2
//   wen*/waddr*/wdata*    registered retirement write ports 0-2 (0 = oldest)
//   count                 occupied entries, 0..64
//
// Build option: define ROB_FLUSH_EN to add the flush input.
module rob_commit #(
  parameter int DEPTH    = 64,
  parameter int RETIRE_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ROB_FLUSH_EN
  input  logic        flush,
`endif
  input  logic [3:0]  alloc_req,
  input  logic [3:0]  alloc_has_dest,
  input  logic [11:0] alloc_dest,
  output logic        alloc_ready,
  output logic [5:0]  rob_locA,
  output logic [5:0]  rob_locB,
  output logic [5:0]  rob_locC,
  output logic [5:0]  rob_locD,
  output logic [2:0]  rob_waddrA,
  output logic [2:0]  rob_waddrB,
  output logic [2:0]  rob_waddrC,
  output logic [2:0]  rob_waddrD,
  output logic        rob_wenA,
  output logic        rob_wenB,
  output logic        rob_wenC,
  output logic        rob_wenD,
  input  logic        cmp_en0,
  input  logic        cmp_en1,
  input  logic        cmp_en2,
  input  logic [5:0]  cmp_tag0,
  input  logic [5:0]  cmp_tag1,
  input  logic [5:0]  cmp_tag2,
  input  logic [15:0] cmp_data0,
  input  logic [15:0] cmp_data1,
  input  logic [15:0] cmp_data2,
  output logic        wen0,
  output logic        wen1,
  output logic        wen2,
  output logic [2:0]  waddr0,
  output logic [2:0]  waddr1,
  output logic [2:0]  waddr2,
  output logic [15:0] wdata0,
  output logic [15:0] wdata1,
  output logic [15:0] wdata2,
  output logic [6:0]  count
);
  localparam int TW = $clog2(DEPTH);
  localparam int CW = TW + 1;
  localparam int KW = $clog2(RETIRE_W + 1);

  logic [DEPTH-1:0] valid_q, done_q, has_dest_q;
  logic [2:0]       dest_q  [DEPTH];
  logic [15:0]      value_q [DEPTH];
  logic [TW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;

  logic             wen_q   [RETIRE_W];
  logic [2:0]       waddr_q [RETIRE_W];
  logic [15:0]      wdata_q [RETIRE_W];

  // Allocation lanes
  logic [3:0]    lane_go;
  logic [TW-1:0] lane_tag  [4];
  logic [2:0]    lane_dest [4];
  logic [2:0]    n_alloc;

  assign alloc_ready = (count_q <= CW'(DEPTH - 4));
  assign lane_go     = alloc_req & {4{alloc_ready}};

  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < 4; i++) begin
      lane_tag[i]  = tail_q + TW'(i);
      lane_dest[i] = alloc_dest[3*i +: 3];
      n_alloc      = n_alloc + {2'b00, lane_go[i]};
    end
  end

  assign rob_locA   = lane_tag[0];
  assign rob_locB   = lane_tag[1];
  assign rob_locC   = lane_tag[2];
  assign rob_locD   = lane_tag[3];
  assign rob_waddrA = lane_dest[0];
  assign rob_waddrB = lane_dest[1];
  assign rob_waddrC = lane_dest[2];
  assign rob_waddrD = lane_dest[3];
  assign rob_wenA   = lane_go[0] & alloc_has_dest[0];
  assign rob_wenB   = lane_go[1] & alloc_has_dest[1];
  assign rob_wenC   = lane_go[2] & alloc_has_dest[2];
  assign rob_wenD   = lane_go[3] & alloc_has_dest[3];

  // Completion ports gathered for indexed access
  logic [2:0]    cmp_en_v;
  logic [TW-1:0] cmp_tag_v  [3];
  logic [15:0]   cmp_data_v [3];

  assign cmp_en_v      = {cmp_en2, cmp_en1, cmp_en0};
  assign cmp_tag_v[0]  = cmp_tag0;
  assign cmp_tag_v[1]  = cmp_tag1;
  assign cmp_tag_v[2]  = cmp_tag2;
  assign cmp_data_v[0] = cmp_data0;
  assign cmp_data_v[1] = cmp_data1;
  assign cmp_data_v[2] = cmp_data2;

  // Retire select: a slot retires only if every older slot in the group does,
  // so the group is always a contiguous run starting at head.
  logic [TW-1:0]       ret_idx [RETIRE_W];
  logic [RETIRE_W-1:0] ret_go;
  logic [KW-1:0]       n_ret;

  always_comb begin : retire_sel
    logic chain;
    chain = 1'b1;
    n_ret = '0;
    for (int j = 0; j < RETIRE_W; j++) begin
      ret_idx[j] = head_q + TW'(j);
      chain      = chain & valid_q[ret_idx[j]] & done_q[ret_idx[j]]
                   & (count_q > CW'(j));
      ret_go[j]  = chain;
      n_ret      = n_ret + KW'(chain);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      for (int j = 0; j < RETIRE_W; j++) begin
        wen_q[j]   <= 1'b0;
        waddr_q[j] <= '0;
        wdata_q[j] <= '0;
      end
    end
`ifdef ROB_FLUSH_EN
    else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      for (int j = 0; j < RETIRE_W; j++) wen_q[j] <= 1'b0;
    end
`endif
    else begin
      // Lane slots are free whenever alloc_ready is high, and retiring slots
      // are already done, so none of the three updates below collide.
      for (int i = 0; i < 4; i++) begin
        if (lane_go[i]) begin
          valid_q[lane_tag[i]]    <= 1'b1;
          done_q[lane_tag[i]]     <= 1'b0;
          has_dest_q[lane_tag[i]] <= alloc_has_dest[i];
          dest_q[lane_tag[i]]     <= lane_dest[i];
        end
      end
      // Highest port applied first so the lowest port's write lands last.
      for (int p = 2; p >= 0; p--) begin
        if (cmp_en_v[p] && valid_q[cmp_tag_v[p]] && !done_q[cmp_tag_v[p]]) begin
          done_q[cmp_tag_v[p]]  <= 1'b1;
          value_q[cmp_tag_v[p]] <= cmp_data_v[p];
        end
      end
      for (int j = 0; j < RETIRE_W; j++) begin
        wen_q[j] <= ret_go[j] & has_dest_q[ret_idx[j]];
        if (ret_go[j]) begin
          valid_q[ret_idx[j]] <= 1'b0;
          waddr_q[j]          <= dest_q[ret_idx[j]];
          wdata_q[j]          <= value_q[ret_idx[j]];
        end
      end
      head_q  <= head_q + TW'(n_ret);
      tail_q  <= tail_q + TW'(n_alloc);
      count_q <= count_q + CW'(n_alloc) - CW'(n_ret);
    end
  end

  assign count  = count_q;
  assign wen0   = wen_q[0];
  assign wen1   = wen_q[1];
  assign wen2   = wen_q[2];
  assign waddr0 = waddr_q[0];
  assign waddr1 = waddr_q[1];
  assign waddr2 = waddr_q[2];
  assign wdata0 = wdata_q[0];
  assign wdata1 = wdata_q[1];
  assign wdata2 = wdata_q[2];

endmodule

// File: tb/tb_rob_commit.sv
module tb_rob_commit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  alloc_req, alloc_has_dest;
  logic [11:0] alloc_dest;
  logic        alloc_ready;
  logic [5:0]  rob_locA, rob_locB, rob_locC, rob_locD;
  logic [2:0]  rob_waddrA, rob_waddrB, rob_waddrC, rob_waddrD;
  logic        rob_wenA, rob_wenB, rob_wenC, rob_wenD;
  logic        cmp_en0, cmp_en1, cmp_en2;
  logic [5:0]  cmp_tag0, cmp_tag1, cmp_tag2;
  logic [15:0] cmp_data0, cmp_data1, cmp_data2;
  logic        wen0, wen1, wen2;
  logic [2:0]  waddr0, waddr1, waddr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [6:0]  count;
`ifdef ROB_FLUSH_EN
  logic        flush;
`endif

  rob_commit dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_req(alloc_req), .alloc_has_dest(alloc_has_dest), .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready),
    .rob_locA(rob_locA), .rob_locB(rob_locB), .rob_locC(rob_locC), .rob_locD(rob_locD),
    .rob_waddrA(rob_waddrA), .rob_waddrB(rob_waddrB), .rob_waddrC(rob_waddrC), .rob_waddrD(rob_waddrD),
    .rob_wenA(rob_wenA), .rob_wenB(rob_wenB), .rob_wenC(rob_wenC), .rob_wenD(rob_wenD),
    .cmp_en0(cmp_en0), .cmp_en1(cmp_en1), .cmp_en2(cmp_en2),
    .cmp_tag0(cmp_tag0), .cmp_tag1(cmp_tag1), .cmp_tag2(cmp_tag2),
    .cmp_data0(cmp_data0), .cmp_data1(cmp_data1), .cmp_data2(cmp_data2),
    .wen0(wen0), .wen1(wen1), .wen2(wen2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .count(count)
  );

  // Reference model: program-ordered list of in-flight instructions.
  typedef struct {
    int tag;
    bit has_dest;
    int dest;
    bit done;
    int value;
  } ent_t;
  typedef struct {
    int dest;
    int value;
  } wr_t;

  ent_t mq[$];
  int   mtail;
  wr_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic set_idle();
    alloc_req = '0; alloc_has_dest = '0; alloc_dest = '0;
    cmp_en0 = 1'b0; cmp_en1 = 1'b0; cmp_en2 = 1'b0;
    cmp_tag0 = '0; cmp_tag1 = '0; cmp_tag2 = '0;
    cmp_data0 = '0; cmp_data1 = '0; cmp_data2 = '0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic set_alloc(input logic [3:0] req, input logic [3:0] hd, input logic [11:0] dst);
    alloc_req = req; alloc_has_dest = hd; alloc_dest = dst;
  endtask

  task automatic set_cmp(input int p, input int tag, input int data);
    case (p)
      0: begin cmp_en0 = 1'b1; cmp_tag0 = 6'(tag); cmp_data0 = 16'(data); end
      1: begin cmp_en1 = 1'b1; cmp_tag1 = 6'(tag); cmp_data1 = 16'(data); end
      default: begin cmp_en2 = 1'b1; cmp_tag2 = 6'(tag); cmp_data2 = 16'(data); end
    endcase
  endtask

  // One clock: check combinational outputs, advance the model, clock, check count.
  task automatic cycle();
    bit         ready;
    int         k;
    logic [5:0] loc [4];
    logic       lw  [4];
    logic [2:0] la  [4];
    logic [2:0] ce;
    int         ct  [3];
    int         cd  [3];
    ent_t       e;
    #1;
    ready = (mq.size() <= 60);
    loc[0] = rob_locA; loc[1] = rob_locB; loc[2] = rob_locC; loc[3] = rob_locD;
    lw[0] = rob_wenA; lw[1] = rob_wenB; lw[2] = rob_wenC; lw[3] = rob_wenD;
    la[0] = rob_waddrA; la[1] = rob_waddrB; la[2] = rob_waddrC; la[3] = rob_waddrD;
    check("alloc_ready", alloc_ready, ready);
    for (int i = 0; i < 4; i++) begin
      check("rob_wen", lw[i], alloc_req[i] & alloc_has_dest[i] & ready);
      if (alloc_req[i]) begin
        check("rob_loc", loc[i], (mtail + i) % 64);
        check("rob_waddr", la[i], alloc_dest[3*i +: 3]);
      end
    end
    ce = {cmp_en2, cmp_en1, cmp_en0};
    ct[0] = cmp_tag0; ct[1] = cmp_tag1; ct[2] = cmp_tag2;
    cd[0] = cmp_data0; cd[1] = cmp_data1; cd[2] = cmp_data2;
`ifdef ROB_FLUSH_EN
    if (flush) begin
      mq.delete();
      mtail = 0;
    end else
`endif
    begin
      k = 0;
      while (k < 3 && k < mq.size() && mq[k].done) k++;
      repeat (k) begin
        e = mq.pop_front();
        if (e.has_dest) sb.push_back('{e.dest, e.value});
      end
      for (int p = 0; p < 3; p++)
        if (ce[p])
          foreach (mq[i])
            if (mq[i].tag == ct[p] && !mq[i].done) begin
              mq[i].done  = 1'b1;
              mq[i].value = cd[p];
            end
      if (ready)
        for (int i = 0; i < 4; i++)
          if (alloc_req[i]) begin
            mq.push_back('{mtail, alloc_has_dest[i], int'(alloc_dest[3*i +: 3]), 1'b0, 0});
            mtail = (mtail + 1) % 64;
          end
    end
    @(posedge clk);
    #1;
    check("count", count, mq.size());
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    sb.delete();
    mtail = 0;
    check("reset_count", count, 0);
    check("reset_ready", alloc_ready, 1);
    check("reset_wen", {wen2, wen1, wen0}, 0);
  endtask

  task automatic drain();
    int guard;
    int np;
    guard = 0;
    while (mq.size() > 0 && guard < 300) begin
      set_idle();
      np = 0;
      foreach (mq[i])
        if (!mq[i].done && np < 3) begin
          set_cmp(np, mq[i].tag, $urandom_range(0, 65535));
          np++;
        end
      cycle();
      guard++;
    end
    if (mq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", mq.size());
    end
    set_idle();
    cycle();
    cycle();
  endtask

  // Retirement monitor: pops the scoreboard for every write the DUT presents.
  initial begin : monitor
    logic        w;
    logic [2:0]  a;
    logic [15:0] d;
    wr_t         e;
    forever begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        case (j)
          0: begin w = wen0; a = waddr0; d = wdata0; end
          1: begin w = wen1; a = waddr1; d = wdata1; end
          default: begin w = wen2; a = waddr2; d = wdata2; end
        endcase
        if (w === 1'b1) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL retire_unexpected: port %0d wrote dest %0d data 0x%0h, expected no write", j, a, d);
          end else begin
            e = sb.pop_front();
            check("retire_waddr", a, e.dest);
            check("retire_wdata", d, e.value);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         d;
    int         guard;
    logic [3:0] req;
    int         r;
    rst_n = 1'b0;
    set_idle();
    mtail = 0;

    // Basic 4-wide allocation after reset
    do_reset();
    set_alloc(4'hF, 4'hF, {3'd4, 3'd3, 3'd2, 3'd1});
    #1;
    check("t1_locA", rob_locA, 0);
    check("t1_locB", rob_locB, 1);
    check("t1_locC", rob_locC, 2);
    check("t1_locD", rob_locD, 3);
    check("t1_wen", {rob_wenD, rob_wenC, rob_wenB, rob_wenA}, 4'hF);
    cycle();
    check("t1_count", count, 4);

    // Out-of-order completion, in-order retirement
    set_idle();
    set_cmp(0, 2, 16'h00AA);
    set_cmp(1, 0, 16'h0011);
    set_cmp(2, 1, 16'h0022);
    cycle();
    set_idle();
    cycle();
    check("t2_wen", {wen2, wen1, wen0}, 3'b111);
    check("t2_waddr", {waddr2, waddr1, waddr0}, {3'd3, 3'd2, 3'd1});
    check("t2_wdata0", wdata0, 16'h0011);
    check("t2_wdata1", wdata1, 16'h0022);
    check("t2_wdata2", wdata2, 16'h00AA);
    check("t2_count", count, 1);
    drain();

    // Younger completion waits for the head
    do_reset();
    set_alloc(4'h3, 4'h3, {6'd0, 3'd6, 3'd5});
    cycle();
    set_idle();
    set_cmp(0, 1, 16'hBEEF);
    cycle();
    set_idle();
    cycle();
    cycle();
    cycle();
    check("t3_hold_count", count, 2);
    check("t3_hold_wen", {wen2, wen1, wen0}, 0);
    set_cmp(0, 0, 16'hCAFE);
    cycle();
    set_idle();
    cycle();
    check("t3_wen", {wen2, wen1, wen0}, 3'b011);
    check("t3_wdata0", wdata0, 16'hCAFE);
    check("t3_wdata1", wdata1, 16'hBEEF);
    check("t3_count", count, 0);

    // Full ROB
    do_reset();
    repeat (16) begin
      set_alloc(4'hF, 4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
      cycle();
    end
    set_alloc(4'hF, 4'hF, 12'hFFF);
    #1;
    check("t4_full_ready", alloc_ready, 0);
    check("t4_full_wen", {rob_wenD, rob_wenC, rob_wenB, rob_wenA}, 0);
    cycle();
    check("t4_full_count", count, 64);
    set_idle();
    set_cmp(0, 0, 16'h1000);
    set_cmp(1, 1, 16'h1001);
    set_cmp(2, 2, 16'h1002);
    cycle();
    set_idle();
    cycle();
    check("t4_count61", count, 61);
    check("t4_ready61", alloc_ready, 0);
    set_cmp(0, 3, 16'h1003);
    set_cmp(1, 4, 16'h1004);
    set_cmp(2, 5, 16'h1005);
    cycle();
    set_idle();
    cycle();
    check("t4_count58", count, 58);
    check("t4_ready58", alloc_ready, 1);
    drain();

    // Wrap-around across entry 63
    guard = 0;
    while (mtail != 62 && guard < 100) begin
      if (mq.size() > 56) drain();
      d = (62 - mtail + 64) % 64;
      if (d > 4) d = 4;
      set_idle();
      set_alloc(4'((1 << d) - 1), 4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
      cycle();
      guard++;
    end
    drain();
    set_alloc(4'hF, 4'hF, {3'd4, 3'd3, 3'd2, 3'd1});
    #1;
    check("t5_locA", rob_locA, 62);
    check("t5_locB", rob_locB, 63);
    check("t5_locC", rob_locC, 0);
    check("t5_locD", rob_locD, 1);
    cycle();
    set_idle();
    set_cmp(0, 62, 16'h2062);
    set_cmp(1, 63, 16'h2063);
    set_cmp(2, 0, 16'h2000);
    cycle();
    set_idle();
    set_cmp(0, 1, 16'h2001);
    cycle();
    check("t5_wen_a", {wen2, wen1, wen0}, 3'b111);
    check("t5_wdata0", wdata0, 16'h2062);
    check("t5_wdata2", wdata2, 16'h2000);
    set_idle();
    cycle();
    check("t5_wen_b", {wen2, wen1, wen0}, 3'b001);
    check("t5_wdata_b", wdata0, 16'h2001);
    check("t5_count", count, 0);

`ifdef ROB_FLUSH_EN
    do_reset();
    set_alloc(4'hF, 4'hF, 12'h123);
    cycle();
    set_alloc(4'hF, 4'hF, 12'h456);
    cycle();
    set_alloc(4'h3, 4'h3, 12'h789);
    cycle();
    check("t6_count10", count, 10);
    set_idle();
    set_cmp(0, 0, 16'h3000);
    set_cmp(1, 1, 16'h3001);
    cycle();
    set_idle();
    flush = 1'b1;
    set_cmp(0, 2, 16'h3002);
    cycle();
    set_idle();
    check("t6_flush_count", count, 0);
    check("t6_flush_wen", {wen2, wen1, wen0}, 0);
    set_alloc(4'h1, 4'h1, 12'h007);
    #1;
    check("t6_locA", rob_locA, 0);
    cycle();
    drain();
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      set_idle();
      r = (c < 750) ? $urandom_range(0, 5) : $urandom_range(0, 3);
      case (r)
        0: req = 4'h0;
        1: req = 4'h1;
        2: req = 4'h3;
        3: req = 4'h7;
        default: req = 4'hF;
      endcase
      set_alloc(req, 4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)));
      for (int p = 0; p < 3; p++) begin
        if ($urandom_range(0, 9) < 7) begin
          if (mq.size() > 0 && $urandom_range(0, 9) != 0)
            set_cmp(p, mq[$urandom_range(0, mq.size() - 1)].tag, $urandom_range(0, 65535));
          else
            set_cmp(p, $urandom_range(0, 63), $urandom_range(0, 65535));
        end
      end
      cycle();
    end
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
